sm_code_mem: RTL

- Responder end of the SM code-memory read interface: accepts warp fetch requests (addr, wid), queues them, reads a synchronous instruction RAM through a fixed-latency pipeline, and returns instruction, warp id and next-PC address to the fetch unit.
- Host-side load port writes kernel code into the RAM before and between launches.
- Sits between the SM fetch stage and (model of) external code memory; one per SM.

---
 rtl/sm_code_mem_if.sv | 34 +++
 rtl/sm_code_mem.sv | 119 +++++++++++
 2 files changed

// File: rtl/sm_code_mem_if.sv
// SM code-memory read interface: fetch request channel and response channel.
// Ports: req valid/addr/wid (fetch -> mem), ready (mem -> fetch),
//        rsp valid/addr/wid/inst/err (mem -> fetch, no back-pressure).
interface sm_code_mem_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int WID_WIDTH  = 2,
  parameter int INST_WIDTH = 32
);
  logic                  code_rd_req_valid_i;
  logic [ADDR_WIDTH-1:0] code_rd_req_addr_i;
  logic [WID_WIDTH-1:0]  code_rd_req_wid_i;
  logic                  code_mem_ready_o;
  logic                  code_rd_rsp_valid_o;
  logic [ADDR_WIDTH-1:0] code_rd_rsp_addr_o;
  logic [WID_WIDTH-1:0]  code_rd_rsp_wid_o;
  logic [INST_WIDTH-1:0] code_rd_rsp_inst_o;
  logic                  code_rd_rsp_err_o;

  // Fetch unit side
  modport master (
    output code_rd_req_valid_i, code_rd_req_addr_i, code_rd_req_wid_i,
    input  code_mem_ready_o,
    input  code_rd_rsp_valid_o, code_rd_rsp_addr_o, code_rd_rsp_wid_o,
    input  code_rd_rsp_inst_o, code_rd_rsp_err_o
  );

  // Code memory side
  modport slave (
    input  code_rd_req_valid_i, code_rd_req_addr_i, code_rd_req_wid_i,
    output code_mem_ready_o,
    output code_rd_rsp_valid_o, code_rd_rsp_addr_o, code_rd_rsp_wid_o,
    output code_rd_rsp_inst_o, code_rd_rsp_err_o
  );
endinterface

// File: rtl/sm_code_mem.sv
// Purpose: SM code memory responder - queues warp fetch requests, reads instruction RAM, returns inst/wid/next-PC.
// Latency: request-to-response 1+MEM_LATENCY cycles minimum; 1 response/cycle sustained.
// Backpressure: ready = queue not full; host writes stall dispatch; responses are never back-pressured.
// Ports: clk, rst_n (sync, active low); rd (slave modport of sm_code_mem_if);
//        code_wr_valid_i/addr_i/data_i host load port into the instruction RAM.
module sm_code_mem #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WID_WIDTH   = 2,
  parameter int INST_WIDTH  = 32,
  parameter int MEM_WORDS   = 1024,
  parameter int FIFO_DEPTH  = 4,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sm_code_mem_if.slave          rd,
  input  logic                  code_wr_valid_i,
  input  logic [ADDR_WIDTH-1:0] code_wr_addr_i,
  input  logic [INST_WIDTH-1:0] code_wr_data_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [CNT_W-1:0]    DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0] WORDS_C = (ADDR_WIDTH+1)'(MEM_WORDS);

  // ---------------- request queue ----------------
  logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
  logic [WID_WIDTH-1:0]  q_wid  [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  push, pop;

  // Ready is held low while reset is asserted so nothing is accepted into a queue about to be flushed.
  assign rd.code_mem_ready_o = rst_n && (count < DEPTH_C);
  assign push = rd.code_rd_req_valid_i && rd.code_mem_ready_o;
  // Host load owns the RAM port this cycle; popping only from registered count means no same-cycle bypass.
  assign pop  = (count != '0) && !code_wr_valid_i;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr] <= rd.code_rd_req_addr_i;
      q_wid[wr_ptr]  <= rd.code_rd_req_wid_i;
    end
  end

  logic [ADDR_WIDTH-1:0] head_addr;
  logic [WID_WIDTH-1:0]  head_wid;
  logic                  head_ok;
  assign head_addr = q_addr[rd_ptr];
  assign head_wid  = q_wid[rd_ptr];
  assign head_ok   = {1'b0, head_addr} < WORDS_C;

  // ---------------- instruction RAM ----------------
  logic [INST_WIDTH-1:0] mem [MEM_WORDS];
  logic                  wr_ok;
  assign wr_ok = {1'b0, code_wr_addr_i} < WORDS_C;

  // Out-of-range writes are dropped rather than aliased onto a low address.
  always_ff @(posedge clk) begin
    if (code_wr_valid_i && wr_ok) mem[code_wr_addr_i[IDX_W-1:0]] <= code_wr_data_i;
  end

  // ---------------- read pipeline ----------------
  // Stage 0 captures the RAM read at dispatch; later stages only delay.
  // Fields are forced to zero in bubbles so the outputs are zero whenever valid is low.
  logic [MEM_LATENCY-1:0]                 p_vld;
  logic [MEM_LATENCY-1:0][ADDR_WIDTH-1:0] p_addr;
  logic [MEM_LATENCY-1:0][WID_WIDTH-1:0]  p_wid;
  logic [MEM_LATENCY-1:0][INST_WIDTH-1:0] p_inst;
  logic [MEM_LATENCY-1:0]                 p_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_vld  <= '0;
      p_addr <= '0;
      p_wid  <= '0;
      p_inst <= '0;
      p_err  <= '0;
    end else begin
      p_vld[0]  <= pop;
      p_addr[0] <= pop ? head_addr + 1'b1 : '0;
      p_wid[0]  <= pop ? head_wid : '0;
      p_inst[0] <= (pop && head_ok) ? mem[head_addr[IDX_W-1:0]] : '0;
      p_err[0]  <= pop && !head_ok;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        p_vld[i]  <= p_vld[i-1];
        p_addr[i] <= p_addr[i-1];
        p_wid[i]  <= p_wid[i-1];
        p_inst[i] <= p_inst[i-1];
        p_err[i]  <= p_err[i-1];
      end
    end
  end

  assign rd.code_rd_rsp_valid_o = p_vld[MEM_LATENCY-1];
  assign rd.code_rd_rsp_addr_o  = p_addr[MEM_LATENCY-1];
  assign rd.code_rd_rsp_wid_o   = p_wid[MEM_LATENCY-1];
  assign rd.code_rd_rsp_inst_o  = p_inst[MEM_LATENCY-1];
  assign rd.code_rd_rsp_err_o   = p_err[MEM_LATENCY-1];

endmodule
